ex_op_sequencer: RTL and testbench

- Sequences the execute stage so it can run multi-cycle FPU ops alongside single-cycle ALU and jump ops.
- Sits between the ID/EX pipeline register and the EX/MEM register. Accepts one op at a time with a valid/ready handshake and stalls upstream while the FPU iterates.
- Captures the EX result (ALU, FPU or PC+4 path) and holds it with valid/ready toward MEM.
- Purely a controller: the datapath is not modified, only stalled and sampled.

---
 rtl/ex_op_sequencer_if.sv | 37 +++
 rtl/ex_op_sequencer.sv | 118 +++++++++++
 tb/tb_ex_op_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_op_sequencer_if.sv
// ex_op_sequencer_if: handshake and datapath-sampling bundle for the execute-stage sequencer.
//   Upstream (ID/EX) : flush, in_valid, in_ready, in_alu_fpu, in_jump_src, in_fpu_op, in_rd
//   EX datapath      : ex_result, fpu_start, fpu_hold
//   Downstream (MEM) : out_valid, out_ready, out_result, out_rd
//   Status           : busy
// The "slave" modport is the sequencer; the "master" modport is its environment.
interface ex_op_sequencer_if #(
  parameter int BUS_WIDTH      = 64,
  parameter int FPU_OP_WIDTH   = 3,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_alu_fpu;
  logic                      in_jump_src;
  logic [FPU_OP_WIDTH-1:0]   in_fpu_op;
  logic [REG_ADDR_WIDTH-1:0] in_rd;
  logic [BUS_WIDTH-1:0]      ex_result;
  logic                      fpu_start;
  logic                      fpu_hold;
  logic                      out_valid;
  logic                      out_ready;
  logic [BUS_WIDTH-1:0]      out_result;
  logic [REG_ADDR_WIDTH-1:0] out_rd;
  logic                      busy;

  modport master (
    output flush, in_valid, in_alu_fpu, in_jump_src, in_fpu_op, in_rd, ex_result, out_ready,
    input  in_ready, fpu_start, fpu_hold, out_valid, out_result, out_rd, busy
  );

  modport slave (
    input  flush, in_valid, in_alu_fpu, in_jump_src, in_fpu_op, in_rd, ex_result, out_ready,
    output in_ready, fpu_start, fpu_hold, out_valid, out_result, out_rd, busy
  );
endinterface

// File: rtl/ex_op_sequencer.sv
// ex_op_sequencer: execute-stage controller that lets multi-cycle FPU ops share
// the EX stage with single-cycle ALU/jump ops. It never alters the datapath; it
// only stalls upstream, tells the FPU when to start/hold, and samples ex_result
// into a held result register offered to MEM with valid/ready.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ex_op_sequencer_if.slave (upstream handshake, FPU control, MEM handshake)
module ex_op_sequencer #(
  parameter int BUS_WIDTH      = 64,
  parameter int FPU_OP_WIDTH   = 3,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ADD_LAT        = 3,
  parameter int MUL_LAT        = 4,
  parameter int DIV_LAT        = 12,
  parameter int SQRT_LAT       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ex_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                    state_q;
  logic [4:0]                count_q;
  logic                      out_valid_q;
  logic                      fpu_hold_q;
  logic [BUS_WIDTH-1:0]      out_result_q;
  logic [REG_ADDR_WIDTH-1:0] out_rd_q;

  logic [4:0] lat_d;
  logic       single_d;
  logic       accept_d;

  // Latency of the presented FPU op; min/max/sign-inject and unknown codes take one cycle.
  always_comb begin
    lat_d = 5'd1;
    case (bus.in_fpu_op)
      FPU_OP_WIDTH'(0), FPU_OP_WIDTH'(1): lat_d = 5'(ADD_LAT);
      FPU_OP_WIDTH'(2):                   lat_d = 5'(MUL_LAT);
      FPU_OP_WIDTH'(3):                   lat_d = 5'(DIV_LAT);
      FPU_OP_WIDTH'(4):                   lat_d = 5'(SQRT_LAT);
      default:                            lat_d = 5'd1;
    endcase
  end

  // Jumps complete in one cycle regardless of in_alu_fpu.
  assign single_d = bus.in_jump_src || !bus.in_alu_fpu || (lat_d == 5'd1);

  // Nothing is accepted while reset is held, so a stalled upstream that keeps
  // in_valid high cannot provoke an fpu_start during reset.
  assign bus.in_ready = rst_n && !bus.flush &&
                        ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
  assign accept_d      = bus.in_valid && bus.in_ready;
  assign bus.fpu_start = accept_d && !single_d;

  assign bus.fpu_hold   = fpu_hold_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_rd     = out_rd_q;
  assign bus.busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= 5'd0;
      out_valid_q  <= 1'b0;
      fpu_hold_q   <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
    end else if (bus.flush) begin
      // Flush beats everything, including a pending MEM handshake.
      state_q     <= IDLE;
      count_q     <= 5'd0;
      out_valid_q <= 1'b0;
      fpu_hold_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept_d) begin
            out_rd_q <= bus.in_rd;
            if (single_d) begin
              // Back-to-back from DONE lands here too, giving no bubble.
              out_result_q <= bus.ex_result;
              state_q      <= DONE;
              out_valid_q  <= 1'b1;
              fpu_hold_q   <= 1'b0;
            end else begin
              count_q     <= lat_d - 5'd1;
              state_q     <= BUSY;
              out_valid_q <= 1'b0;
              fpu_hold_q  <= 1'b1;
            end
          end else if ((state_q == DONE) && bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          count_q <= count_q - 5'd1;
          // count==1 marks the FPU's final cycle: its result is on ex_result now.
          if (count_q == 5'd1) begin
            out_result_q <= bus.ex_result;
            state_q      <= DONE;
            out_valid_q  <= 1'b1;
            fpu_hold_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          fpu_hold_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_op_sequencer.sv
// tb_ex_op_sequencer: scoreboard bench for ex_op_sequencer. Expected results and
// their due cycles are queued when an op is accepted; a negedge monitor checks
// the first out_valid cycle of each result and its value at the MEM handshake.
module tb_ex_op_sequencer;
  localparam int BW = 64;
  localparam int OW = 3;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_op_sequencer_if #(.BUS_WIDTH(BW), .FPU_OP_WIDTH(OW), .REG_ADDR_WIDTH(RW)) bus ();

  ex_op_sequencer #(
    .BUS_WIDTH(BW), .FPU_OP_WIDTH(OW), .REG_ADDR_WIDTH(RW),
    .ADD_LAT(3), .MUL_LAT(4), .DIV_LAT(12), .SQRT_LAT(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [BW-1:0] res;
    logic [RW-1:0] rd;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   head_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat_of(input logic af, input logic jmp, input logic [2:0] op);
    if (jmp || !af) return 1;
    case (op)
      3'd0, 3'd1: return 3;
      3'd2:       return 4;
      3'd3:       return 12;
      3'd4:       return 16;
      default:    return 1;
    endcase
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", 64'd1, 64'd0);
      end else begin
        if (!head_seen) begin
          check("valid_latency", 64'(cyc), 64'(sb[0].due));
          head_seen = 1'b1;
        end
        if (bus.out_ready && !bus.flush) begin
          exp_t e;
          e = sb.pop_front();
          head_seen = 1'b0;
          check("sb_result", bus.out_result, e.res);
          check("sb_rd", 64'(bus.out_rd), 64'(e.rd));
          $display("txn: result=0x%0h rd=%0d at cycle %0d", bus.out_result, bus.out_rd, cyc);
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.ex_result = {$urandom, $urandom};
  endtask

  // Present an op and wait (bounded) for the accept; returns at the negedge of the accept cycle.
  task automatic start_op(input logic af, input logic jmp, input logic [2:0] op,
                          input logic [RW-1:0] rd, input logic [BW-1:0] res,
                          input bit immediate, output int lat, output int t_acc);
    int waited;
    lat = lat_of(af, jmp, op);
    bus.in_valid    = 1'b1;
    bus.in_alu_fpu  = af;
    bus.in_jump_src = jmp;
    bus.in_fpu_op   = op;
    bus.in_rd       = rd;
    bus.ex_result   = (lat == 1) ? res : ~res;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) check("accept_timeout", 64'd0, 64'd1);
    if (immediate) check("accept_wait", 64'(waited), 64'd0);
    check("fpu_start_at_accept", 64'(bus.fpu_start), 64'(lat > 1));
    t_acc = cyc;
  endtask

  // Full op: singles return in cycle t+1 with in_valid still high; multis return at t+L with in_valid low.
  task automatic issue_op(input logic af, input logic jmp, input logic [2:0] op,
                          input logic [RW-1:0] rd, input logic [BW-1:0] res, input bit immediate);
    int lat, t;
    exp_t e;
    start_op(af, jmp, op, rd, res, immediate, lat, t);
    e.res = res; e.rd = rd; e.due = t + lat;
    sb.push_back(e);
    $display("txn: accept op af=%0b jmp=%0b fpu_op=%0d rd=%0d res=0x%0h lat=%0d at cycle %0d",
             af, jmp, op, rd, res, lat, t);
    if (lat > 1) begin
      for (int k = 1; k < lat; k++) begin
        next();
        if (k == lat - 1) bus.ex_result = res;
        @(negedge clk);
        check("busy_in_ready", 64'(bus.in_ready), 64'd0);
        check("busy_fpu_start", 64'(bus.fpu_start), 64'd0);
        check("busy_fpu_hold", 64'(bus.fpu_hold), 64'd1);
      end
      next();
      bus.ex_result = ~res;
      bus.in_valid  = 1'b0;
    end else begin
      next();
    end
  endtask

  initial begin
    int lat, t;
    rst_n           = 1'b0;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_alu_fpu  = 1'b0;
    bus.in_jump_src = 1'b0;
    bus.in_fpu_op   = '0;
    bus.in_rd       = '0;
    bus.ex_result   = '0;
    bus.out_ready   = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_result", bus.out_result, 64'd0);
    check("rst_out_rd", 64'(bus.out_rd), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_fpu_hold", 64'(bus.fpu_hold), 64'd0);
    check("rst_fpu_start", 64'(bus.fpu_start), 64'd0);
    next();
    rst_n = 1'b1;
    next();

    // Single ALU op: busy for exactly one cycle.
    issue_op(1'b0, 1'b0, 3'd0, 5'd5, 64'h1234, 1'b1);
    idle();
    @(negedge clk);
    check("alu_busy_t1", 64'(bus.busy), 64'd1);
    next();
    @(negedge clk);
    check("alu_busy_t2", 64'(bus.busy), 64'd0);
    check("alu_valid_t2", 64'(bus.out_valid), 64'd0);
    next();

    // FDIV, 12 cycles.
    issue_op(1'b1, 1'b0, 3'd3, 5'd7, 64'hD1D1_0000_CAFE_0001, 1'b1);
    next();

    // Three back-to-back ALU ops.
    issue_op(1'b0, 1'b0, 3'd2, 5'd1, 64'hA1, 1'b1);
    issue_op(1'b0, 1'b0, 3'd3, 5'd2, 64'hA2, 1'b1);
    issue_op(1'b0, 1'b0, 3'd4, 5'd3, 64'hA3, 1'b1);
    idle();
    next();

    // FADD, FPU sign-inject (single), jump with in_alu_fpu=1 (jump wins).
    issue_op(1'b1, 1'b0, 3'd0, 5'd11, 64'h0ADD, 1'b1);
    issue_op(1'b1, 1'b0, 3'd5, 5'd12, 64'h0005, 1'b1);
    issue_op(1'b1, 1'b1, 3'd3, 5'd13, 64'h0200, 1'b1);
    idle();
    next();

    // FMUL with MEM stalled for 5 cycles; next op waits for out_ready.
    bus.out_ready = 1'b0;
    issue_op(1'b1, 1'b0, 3'd2, 5'd9, 64'h0000_0000_4D55_4C00, 1'b1);
    bus.in_valid    = 1'b1;
    bus.in_alu_fpu  = 1'b0;
    bus.in_jump_src = 1'b0;
    bus.in_rd       = 5'd10;
    bus.ex_result   = 64'hBEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_out_result", bus.out_result, 64'h0000_0000_4D55_4C00);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      next();
    end
    bus.out_ready = 1'b1;
    issue_op(1'b0, 1'b0, 3'd0, 5'd10, 64'hBEEF, 1'b1);
    idle();
    next();

    // Flush at t+2 of FSQRT, then a jal right after.
    start_op(1'b1, 1'b0, 3'd4, 5'd20, 64'h5151, 1'b1, lat, t);
    next();
    next();
    bus.flush    = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    check("flush_busy_still", 64'(bus.busy), 64'd1);
    next();
    bus.flush = 1'b0;
    issue_op(1'b0, 1'b1, 3'd0, 5'd1, 64'h104, 1'b1);
    idle();
    for (int i = 0; i < 18; i++) next();
    @(negedge clk);
    check("post_flush_no_valid", 64'(bus.out_valid), 64'd0);
    next();

    // Async reset mid-BUSY with upstream still holding the op.
    start_op(1'b1, 1'b0, 3'd3, 5'd25, 64'h2525, 1'b1, lat, t);
    next();
    next();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_fpu_hold", 64'(bus.fpu_hold), 64'd0);
    check("arst_fpu_start", 64'(bus.fpu_start), 64'd0);
    check("arst_out_result", bus.out_result, 64'd0);
    bus.in_valid = 1'b0;
    next();
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("post_arst_quiet", 64'({bus.out_valid, bus.fpu_start, bus.busy}), 64'd0);
      next();
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
